// File: rtl/trig_bcd_accum.sv
// Trigger-driven decimal accumulator: each accepted trigger applies one per-channel op to a binary
// value, locks out for a cooldown window, and a multi-cycle double-dabble drives packed BCD digits.
module trig_bcd_accum #(
  parameter int                  N_TRIG   = 4,
  parameter int                  N_DIGITS = 4,
  parameter int                  COOLDOWN = 1024,
  parameter logic [2*N_TRIG-1:0] OP_TYPE  = 8'b01_01_00_00,
  parameter logic [4*N_TRIG-1:0] OP_CONST = 16'h3_2_3_1,
  parameter bit                  SAT_MODE = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Clear,
  input  logic [N_TRIG-1:0]     Trigger,
  output logic [4*N_DIGITS-1:0] BCD,
  output logic                  Overflow,
  output logic                  Busy,
  output logic                  DispValid,
  output logic [0:0]            dbg_state
);

  localparam int MAXV = 10**N_DIGITS - 1;
  localparam int VW   = $clog2(MAXV + 1);
  localparam int OW   = VW + 4;
  localparam int CW   = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int SW   = $clog2(VW + 1);
  localparam int BW   = 4 * N_DIGITS;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_COOL = 1'b1;

  logic [0:0]        state;
  logic [N_TRIG-1:0] trig_reg;
  logic [VW-1:0]     value;
  logic [CW-1:0]     cnt;
  logic              overflow;
  logic [BW-1:0]     bcd_reg;
  logic              disp_valid;
  logic              conv_start;
  logic              conv_busy;
  logic [SW-1:0]     shift_cnt;
  logic [VW-1:0]     bin_sh;
  logic [BW-1:0]     dig;

  int            sel;
  logic [1:0]    op;
  logic [3:0]    opc;
  logic [OW-1:0] v_ext;
  logic [OW-1:0] c_ext;
  logic [OW-1:0] res;
  logic          over;
  logic          accept;
  logic          write_val;
  logic [VW-1:0] next_val;
  logic [3:0]    nib;
  logic [BW-1:0] adj;
  logic [BW-1:0] dig_next;

  // Lowest set trigger bit picks the channel.
  always_comb begin
    sel = 0;
    for (int i = N_TRIG - 1; i >= 0; i--) begin
      if (Trigger[i]) sel = i;
    end
    op    = OP_TYPE[2*sel +: 2];
    opc   = OP_CONST[4*sel +: 4];
    v_ext = OW'(value);
    c_ext = OW'(opc);
    case (op)
      2'b00:   res = v_ext + c_ext;
      2'b01:   res = v_ext * c_ext;
      2'b10:   res = (v_ext < c_ext) ? '0 : v_ext - c_ext;
      default: res = v_ext;
    endcase
    over     = (res > OW'(MAXV));
    accept   = (state == S_IDLE) && (Trigger != '0) && (Trigger != trig_reg);
    // Without saturation an overflowing result, or any op once overflowed, leaves the value frozen.
    write_val = accept && (op != 2'b11) && (SAT_MODE || (!overflow && !over));
    next_val  = over ? VW'(MAXV) : res[VW-1:0];
  end

  always_comb begin
    nib = '0;
    adj = '0;
    for (int d = 0; d < N_DIGITS; d++) begin
      nib = dig[4*d +: 4];
      adj[4*d +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    dig_next = {adj[BW-2:0], bin_sh[VW-1]};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      trig_reg   <= '0;
      value      <= '0;
      cnt        <= '0;
      overflow   <= 1'b0;
      bcd_reg    <= '0;
      disp_valid <= 1'b1;
      conv_start <= 1'b0;
      conv_busy  <= 1'b0;
      shift_cnt  <= '0;
      bin_sh     <= '0;
      dig        <= '0;
    end else if (Clear) begin
      state      <= S_IDLE;
      trig_reg   <= '0;
      value      <= '0;
      cnt        <= '0;
      overflow   <= 1'b0;
      disp_valid <= 1'b0;
      conv_start <= 1'b1;
      conv_busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Trigger == '0) begin
            trig_reg <= '0;
          end else if (accept) begin
            trig_reg <= Trigger;
            state    <= S_COOL;
            cnt      <= '0;
            if (over) overflow <= 1'b1;
            if (write_val) value <= next_val;
          end
        end
        default: begin
          if (cnt == CW'(COOLDOWN - 1)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase

      // One load cycle then VW shift cycles; a new value write restarts from the load.
      if (write_val) begin
        conv_start <= 1'b1;
        conv_busy  <= 1'b0;
        disp_valid <= 1'b0;
      end else if (conv_start) begin
        conv_start <= 1'b0;
        conv_busy  <= 1'b1;
        bin_sh     <= value;
        dig        <= '0;
        shift_cnt  <= '0;
      end else if (conv_busy) begin
        dig       <= dig_next;
        bin_sh    <= bin_sh << 1;
        shift_cnt <= shift_cnt + 1'b1;
        if (shift_cnt == SW'(VW - 1)) begin
          conv_busy  <= 1'b0;
          bcd_reg    <= dig_next;
          disp_valid <= 1'b1;
        end
      end
    end
  end

  assign BCD       = (!SAT_MODE && overflow) ? {BW{1'b1}} : bcd_reg;
  assign Overflow  = overflow;
  assign Busy      = (state == S_COOL);
  assign DispValid = disp_valid;
  assign dbg_state = state;

endmodule
